alu_mul_seq: RTL and testbench

//  Iterative unsigned multiplier sequencer built around one shared ALU instance (add op, m=3'b000).

---
 rtl/alu_mul_seq.sv | 131 +++++++++++++
 tb/tb_alu_mul_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier for the EX-stage MUL slot.
// One operand pair is accepted over in_valid/in_ready, WIDTH add-and-shift
// steps run through a single shared ALU, and the 2*WIDTH-bit product is
// offered over out_valid/out_ready.
//
// Handshake semantics (both ports): a transfer happens on a posedge where
// valid and ready are both 1. The producer holds its data stable while
// valid=1 and ready=0. Ready and valid driven by this block are decoded
// from registered state only, so neither depends combinationally on the
// opposite side's valid/ready.

// Small combinational ALU; the multiplier only ever selects the add op.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       m,
  output logic [WIDTH-1:0] y,
  output logic             cf
);

  // Operation select; cf is carry for add and borrow for sub, 0 otherwise.
  always_comb begin
    y  = '0;
    cf = 1'b0;
    case (m)
      3'b000:  {cf, y} = {1'b0, a} + {1'b0, b};
      3'b001:  {cf, y} = {1'b0, a} - {1'b0, b};
      3'b010:  y = a & b;
      3'b011:  y = a | b;
      3'b100:  y = a ^ b;
      default: y = a;
    endcase
  end

endmodule

module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic             zf,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] alu_y;
  logic             alu_cf;

  // Partial-sum adder: accumulator high half plus the latched multiplicand.
  alu #(.WIDTH(WIDTH)) u_alu (
    .a  (p_hi),
    .b  (mcand),
    .m  (3'b000),
    .y  (alu_y),
    .cf (alu_cf)
  );

  // Sequencer: latch operands, run WIDTH shift-add steps, hold the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            p_hi  <= '0;
            p_lo  <= b;
            mcand <= a;
            cnt   <= CW'(WIDTH);
            state <= RUN;
          end
        end
        RUN: begin
          // The add carry shifts into the top bit, so no product bit is lost.
          if (p_lo[0]) begin
            {p_hi, p_lo} <= {alu_cf, alu_y, p_lo[WIDTH-1:1]};
          end else begin
            {p_hi, p_lo} <= {1'b0, p_hi, p_lo[WIDTH-1:1]};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state; P is visible throughout but is only
  // meaningful while out_valid=1.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign prod_hi   = p_hi;
  assign prod_lo   = p_lo;
  assign zf        = ~|{p_hi, p_lo};
  assign state_dbg = state;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: directed corner cases plus randomized traffic,
// checked against a plain a*b reference through an expected queue.
module tb_alu_mul_seq;

  localparam int W = 32;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   prod_hi;
  logic [W-1:0]   prod_lo;
  logic           zf;
  logic [1:0]     state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mul_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod_hi   (prod_hi),
    .prod_lo   (prod_lo),
    .zf        (zf),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];
  int             acc_q[$];
  int             n_checks = 0;
  int             n_fail   = 0;
  int             n_sent   = 0;
  int             n_recv   = 0;
  bit             hold_ready = 1'b0;
  bit             rand_ready = 1'b0;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] xx;
    logic [2*W-1:0] yy;
    xx = {{W{1'b0}}, x};
    yy = {{W{1'b0}}, y};
    return xx * yy;
  endfunction

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  bit             seen = 1'b0;
  bit             held = 1'b0;
  logic [2*W-1:0] last_p;
  logic           last_zf;

  initial out_ready = 1'b0;

  // Samples on the falling edge, decides out_ready for the next rising edge,
  // and scores the product when that edge will complete the transfer.
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (out_valid) begin
      chk("in_ready_low_in_done", {63'd0, in_ready}, 64'd0);
      if (!seen) begin
        if (acc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h expected none", {prod_hi, prod_lo});
        end else begin
          chk("latency", 64'(cyc - acc_q[0]), 64'(W));
        end
        seen = 1'b1;
      end
      if (held) begin
        chk("stable_prod", {prod_hi, prod_lo}, last_p);
        chk("stable_zf", {63'd0, zf}, {63'd0, last_zf});
      end
      last_p  = {prod_hi, prod_lo};
      last_zf = zf;
      out_ready = hold_ready ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_product: got %h expected none", {prod_hi, prod_lo});
        end else begin
          e = exp_q.pop_front();
          void'(acc_q.pop_front());
          chk("product", {prod_hi, prod_lo}, e);
          chk("zf", {63'd0, zf}, {63'd0, (e == '0)});
          n_recv++;
        end
        seen = 1'b0;
        held = 1'b0;
      end else begin
        held = 1'b1;
      end
    end else begin
      out_ready = hold_ready ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      held = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Called on a falling edge; returns on a falling edge after acceptance.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    bit done;
    bit rdy;
    done = 1'b0;
    a = x;
    b = y;
    in_valid = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      rdy = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) begin
        exp_q.push_back(ref_mul(x, y));
        acc_q.push_back(cyc);
        n_sent++;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 500 cycles");
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_idle_after_reset(input string tag);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_prod"}, {prod_hi, prod_lo}, 64'd0);
    chk({tag, "_zf"}, {63'd0, zf}, 64'd1);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_idle_after_reset("reset");

    // Directed: small, carry-heavy maximum, zero multiplier.
    send(32'd3, 32'd5);
    drain();
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    send(32'h1234_5678, 32'd0);
    drain();
    send(32'd0, 32'hDEAD_BEEF);
    drain();

    // Consumer stalls in DONE while a new operand pair is offered.
    hold_ready = 1'b1;
    send(32'd1000, 32'd1000);
    for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
    chk("hold_reached_done", {63'd0, out_valid}, 64'd1);
    a = 32'd9;
    b = 32'd9;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    hold_ready = 1'b0;
    drain();

    // Reset in the middle of a multiply discards it.
    a = 32'd123;
    b = 32'd456;
    in_valid = 1'b1;
    chk("pre_reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_after_reset("mid_run_reset");
    send(32'd7, 32'd6);
    drain();

    // Random back-to-back traffic with random gaps and backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(pick_operand(), pick_operand());
    end
    drain();
    rand_ready = 1'b0;
    repeat (5) @(negedge clk);

    chk("sent_vs_received", 64'(n_recv), 64'(n_sent));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
